comparator_scan_sequencer: RTL
==============================

Name: comparator_scan_sequencer

Overview:
- Automates a halfstrip scan through the comparator injector.
- For each halfstrip in a configured range it:
  - selects that halfstrip;
  - clears the error counters;
  - fires a pulse train and waits for the pulser handshake;
  - captures compout_errcnt into a per-halfstrip result register file.
- Sits between the slow-control register block (start, range, readback) and comparator_injector, replacing manual per-halfstrip firing.

Parameters:
- NHALFSTRIPS, 32, number of halfstrips; result file depth. Fixed at 32 (5-bit address).
- ERRCNT_W, 16, width of compout_errcnt and of each result entry.
- SETTLE_CYCLES, 8, cycles waited after a counter reset and after the pulse train, before the next action.
- TIMEOUT_CYCLES, 4095, maximum cycles spent in any pulser-wait state.

Ports:
- clock  in  1  system clock (40 MHz BX clock).
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan; ignored while busy.
- abort  in  1  terminates the scan; has priority over everything except reset.
- first_hs  in  5  first halfstrip of the scan, sampled on start.
- last_hs  in  5  last halfstrip of the scan (inclusive), sampled on start.
- pulser_ready  in  1  from comparator_injector; 1 = pulser idle.
- compout_errcnt  in  ERRCNT_W  from comparator_injector.
- active_halfstrip  out  5  to comparator_injector.
- fire_pulse  out  1  to comparator_injector; one-cycle strobe.
- compout_errcnt_rst  out  1  to comparator_injector.
- thresholds_errcnt_rst  out  1  to comparator_injector.
- offsets_errcnt_rst  out  1  to comparator_injector.
- busy  out  1  scan in progress.
- done  out  1  sticky; scan completed normally. Cleared by start or reset.
- cfg_err  out  1  sticky; first_hs > last_hs at start. Cleared by next start or reset.
- timeout  out  1  sticky; at least one pulser wait timed out. Cleared by start or reset.
- fail_mask  out  NHALFSTRIPS  bit n = 1 if result[n] != 0. Cleared by start or reset.
- rd_addr  in  5  result readback address.
- rd_data  out  ERRCNT_W  result[rd_addr], registered, 1-cycle latency.

Behaviour:
- Reset (synchronous, every output):
  - all 1-bit outputs 0; active_halfstrip 0; fail_mask 0; rd_data 0;
  - all result entries 0; FSM to IDLE.
- Every output is registered.
- IDLE:
  - on start with first_hs <= last_hs: latch first_hs/last_hs; set active_halfstrip=first_hs; clear done/timeout/fail_mask/result; busy=1; go to RST.
  - on start with first_hs > last_hs: set cfg_err=1; stay in IDLE; busy stays 0; done stays 0.
- RST:
  - assert all three *_errcnt_rst for exactly 1 cycle, then go to SETTLE_A.
- SETTLE_A:
  - count SETTLE_CYCLES cycles (lets the halfstrip mask and injector inputs settle), then go to ARM.
- ARM:
  - wait for pulser_ready=1, then assert fire_pulse for exactly 1 cycle and go to WAIT_BUSY.
- WAIT_BUSY:
  - wait for pulser_ready=0, then go to WAIT_DONE.
- WAIT_DONE:
  - wait for pulser_ready=1, then go to SETTLE_B.
- SETTLE_B:
  - count SETTLE_CYCLES (drains the compare pipeline), then go to CAPTURE.
- CAPTURE (1 cycle):
  - result[active_halfstrip] <= compout_errcnt; fail_mask bit set if nonzero.
  - if active_halfstrip == last_hs: go to IDLE, busy=0, done=1.
  - otherwise: active_halfstrip+1, go to RST.
- Timeout:
  - a single wait counter is cleared on every state entry.
  - if ARM, WAIT_BUSY or WAIT_DONE reaches TIMEOUT_CYCLES: set timeout=1; write result = all-ones (16'hFFFF); set the fail_mask bit; proceed as from CAPTURE (skip SETTLE_B).
- Range and wrap-around:
  - first_hs == last_hs produces exactly one capture.
  - last_hs = 31 ends the scan without wrapping active_halfstrip to 0.
- abort in any non-IDLE state:
  - next cycle: FSM=IDLE, busy=0, fire_pulse=0, all *_rst=0.
  - done is not set; results captured so far are retained; active_halfstrip holds.
  - abort in the same cycle as start: start is ignored.
- Start while busy: ignored; no restart.
- Mid-scan reset: full reset as above; results cleared.
- Readback: legal at any time; returns the last written value.

Decomposition:
- Shared package scan_pkg holds:
  - FSM state enum: IDLE, RST, SETTLE_A, ARM, WAIT_BUSY, WAIT_DONE, SETTLE_B, CAPTURE;
  - ERRCNT_W and the TIMEOUT_RESULT constant (all-ones);
  - the halfstrip index width (5).
- One sub-module, scan_result_ram: 32 x ERRCNT_W register file with synchronous clear, single write port and registered read port.

Test Plan:
- first_hs=17, last_hs=17, injector model returns errcnt 0 -> exactly 1 fire_pulse, active_halfstrip=17 throughout, done=1, fail_mask=0, rd_addr=17 gives 0.
- first_hs=0, last_hs=31, model returns errcnt = hs index -> 32 fire strobes, each preceded by a 1-cycle rst pulse; fail_mask=32'hFFFFFFFE; rd_addr=5 gives 5; done=1.
- pulser_ready held 0 at hs 3 of a 2..4 scan -> after 4095 cycles timeout=1, result[3]=16'hFFFF, fail_mask bit 3 set, hs 4 still scanned, done=1.
- abort asserted in WAIT_DONE at hs 10 of 8..12 -> busy=0 next cycle, done=0, result[8..9] retained, result[10] unchanged (0); a new start then clears everything.
- first_hs=20, last_hs=5 -> cfg_err=1, busy stays 0, no fire_pulse; a following valid start clears cfg_err.
- start pulsed again mid-scan, and reset pulsed in SETTLE_B -> second start ignored; reset returns all outputs and results to 0 the next cycle.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the comparator halfstrip scan sequencer.
package scan_pkg;
    localparam int HS_W        = 5;
    localparam int NHALFSTRIPS = 32;
    localparam int ERRCNT_W    = 16;

    localparam logic [ERRCNT_W-1:0] TIMEOUT_RESULT = '1;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        SETTLE_A,
        ARM,
        WAIT_BUSY,
        WAIT_DONE,
        SETTLE_B,
        CAPTURE
    } state_t;
endpackage

// File: rtl/comparator_scan_sequencer_if.sv
// Sequencer <-> comparator_injector link: halfstrip select, fire/reset strobes, pulser status.
interface comparator_scan_sequencer_if;
    import scan_pkg::*;

    logic [HS_W-1:0]     active_halfstrip;
    logic                fire_pulse;
    logic                compout_errcnt_rst;
    logic                thresholds_errcnt_rst;
    logic                offsets_errcnt_rst;
    logic                pulser_ready;
    logic [ERRCNT_W-1:0] compout_errcnt;

    modport master (
        output active_halfstrip, fire_pulse,
        output compout_errcnt_rst, thresholds_errcnt_rst, offsets_errcnt_rst,
        input  pulser_ready, compout_errcnt
    );

    modport slave (
        input  active_halfstrip, fire_pulse,
        input  compout_errcnt_rst, thresholds_errcnt_rst, offsets_errcnt_rst,
        output pulser_ready, compout_errcnt
    );
endinterface

// File: rtl/scan_result_ram.sv
// Per-halfstrip result file: synchronous clear, one write port, registered read port.
module scan_result_ram
    import scan_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                we_i,
    input  logic [HS_W-1:0]     waddr_i,
    input  logic [ERRCNT_W-1:0] wdata_i,
    input  logic [HS_W-1:0]     raddr_i,
    output logic [ERRCNT_W-1:0] rdata_o
);
    logic [ERRCNT_W-1:0] mem_q [NHALFSTRIPS];
    logic [ERRCNT_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NHALFSTRIPS; i++) mem_q[i] <= '0;
            rdata_q <= '0;
        end else begin
            if (clr_i) begin
                for (int i = 0; i < NHALFSTRIPS; i++) mem_q[i] <= '0;
            end else if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/comparator_scan_sequencer.sv
// Steps through a halfstrip range: reset counters, settle, fire, wait for pulser, drain, capture errcnt.
module comparator_scan_sequencer
    import scan_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [HS_W-1:0]            first_hs,
    input  logic [HS_W-1:0]            last_hs,
    comparator_scan_sequencer_if.master inj,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err,
    output logic                       timeout,
    output logic [NHALFSTRIPS-1:0]     fail_mask,
    input  logic [HS_W-1:0]            rd_addr,
    output logic [ERRCNT_W-1:0]        rd_data
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [HS_W-1:0]        act_q, act_d;
    logic [HS_W-1:0]        last_q, last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   cfg_q, cfg_d;
    logic                   tmo_q, tmo_d;
    logic [NHALFSTRIPS-1:0] fail_q, fail_d;
    logic                   fire_q, fire_d;
    logic                   rst_q, rst_d;

    logic                   we, clr, finish, tmo_hit;
    logic [ERRCNT_W-1:0]    wdata;

    assign tmo_hit = (cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = done_q;
        cfg_d   = cfg_q;
        tmo_d   = tmo_q;
        fail_d  = fail_q;
        fire_d  = 1'b0;
        we      = 1'b0;
        clr     = 1'b0;
        finish  = 1'b0;
        wdata   = inj.compout_errcnt;

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        if (first_hs <= last_hs) begin
                            act_d   = first_hs;
                            last_d  = last_hs;
                            done_d  = 1'b0;
                            tmo_d   = 1'b0;
                            cfg_d   = 1'b0;
                            fail_d  = '0;
                            clr     = 1'b1;
                            busy_d  = 1'b1;
                            state_d = RST;
                        end else begin
                            cfg_d = 1'b1;
                        end
                    end
                end
                RST:      state_d = SETTLE_A;
                SETTLE_A: if (cnt_q == SETTLE_LAST) state_d = ARM;
                ARM: begin
                    if (inj.pulser_ready) begin
                        fire_d  = 1'b1;
                        state_d = WAIT_BUSY;
                    end else if (tmo_hit) begin
                        finish = 1'b1;
                    end
                end
                WAIT_BUSY: begin
                    if (!inj.pulser_ready) state_d = WAIT_DONE;
                    else if (tmo_hit)      finish  = 1'b1;
                end
                WAIT_DONE: begin
                    if (inj.pulser_ready) state_d = SETTLE_B;
                    else if (tmo_hit)     finish  = 1'b1;
                end
                SETTLE_B: if (cnt_q == SETTLE_LAST) state_d = CAPTURE;
                CAPTURE:  finish = 1'b1;
                default:  state_d = IDLE;
            endcase

            // A finish outside CAPTURE can only come from a pulser-wait timeout.
            if (finish && state_q != CAPTURE) begin
                tmo_d = 1'b1;
                wdata = TIMEOUT_RESULT;
            end
            if (finish) begin
                we = 1'b1;
                if (wdata != '0) fail_d[act_q] = 1'b1;
                if (act_q == last_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    act_d   = act_q + 1'b1;
                    state_d = RST;
                end
            end
        end

        rst_d = (state_d == RST);
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            act_q   <= '0;
            last_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cfg_q   <= 1'b0;
            tmo_q   <= 1'b0;
            fail_q  <= '0;
            fire_q  <= 1'b0;
            rst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cfg_q   <= cfg_d;
            tmo_q   <= tmo_d;
            fail_q  <= fail_d;
            fire_q  <= fire_d;
            rst_q   <= rst_d;
        end
    end

    scan_result_ram u_ram (
        .clk_i   (clock),
        .rst_i   (reset),
        .clr_i   (clr),
        .we_i    (we),
        .waddr_i (act_q),
        .wdata_i (wdata),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign inj.active_halfstrip      = act_q;
    assign inj.fire_pulse            = fire_q;
    assign inj.compout_errcnt_rst    = rst_q;
    assign inj.thresholds_errcnt_rst = rst_q;
    assign inj.offsets_errcnt_rst    = rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_q;
    assign timeout   = tmo_q;
    assign fail_mask = fail_q;
endmodule
